// File: rtl/victim_fill_controller_lx_pkg.sv
// rtl/victim_fill_controller_lx_pkg.sv - shared helpers, widths and state encoding for the Lx victim fill controller
package victim_fill_controller_lx_pkg;

   function automatic int way_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   function automatic int line_addr_bits(input int tag_bits, input int index_bits);
      return tag_bits + index_bits;
   endfunction

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SELECT     = 3'd1;
   localparam logic [2:0] ST_READ       = 3'd2;
   localparam logic [2:0] ST_WRITEBACK  = 3'd3;
   localparam logic [2:0] ST_FETCH_REQ  = 3'd4;
   localparam logic [2:0] ST_FETCH_WAIT = 3'd5;
   localparam logic [2:0] ST_INSTALL    = 3'd6;

   typedef enum logic [2:0] {
      IDLE       = ST_IDLE,
      SELECT     = ST_SELECT,
      READ       = ST_READ,
      WRITEBACK  = ST_WRITEBACK,
      FETCH_REQ  = ST_FETCH_REQ,
      FETCH_WAIT = ST_FETCH_WAIT,
      INSTALL    = ST_INSTALL
   } fill_state_t;

endpackage

// File: rtl/way_encoder_lx.sv
// rtl/way_encoder_lx.sv - one-hot to binary way encoder; lowest set bit wins, all-zero gives way 0
module way_encoder_lx
   import victim_fill_controller_lx_pkg::*;
#(
   parameter int NUMBER_OF_WAYS = 8,
   localparam int WAY_BITS = way_log2(NUMBER_OF_WAYS)
) (
   input  logic [NUMBER_OF_WAYS-1:0] one_hot,
   output logic [WAY_BITS-1:0]       way
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      way = '0;
      for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--)
         if (one_hot[i]) way = WAY_BITS'(i);
   end

endmodule

// File: rtl/victim_fill_controller_lx.sv
// rtl/victim_fill_controller_lx.sv - Lx miss engine: victim read, optional writeback, line fetch, install and LRU update
module victim_fill_controller_lx
   import victim_fill_controller_lx_pkg::*;
#(
   parameter int NUMBER_OF_WAYS = 8,
   parameter int INDEX_BITS     = 8,
   parameter int TAG_BITS       = 20,
   parameter int LINE_BITS      = 128,
   localparam int WAY_BITS  = way_log2(NUMBER_OF_WAYS),
   localparam int ADDR_BITS = line_addr_bits(TAG_BITS, INDEX_BITS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      miss_valid,
   output logic                      miss_ready,
   input  logic [INDEX_BITS-1:0]     miss_index,
   input  logic [TAG_BITS-1:0]       miss_tag,
   input  logic [NUMBER_OF_WAYS-1:0] selected_way,
   output logic                      arr_rd_en,
   output logic [INDEX_BITS-1:0]     arr_rd_index,
   output logic [WAY_BITS-1:0]       arr_rd_way,
   input  logic                      arr_rd_valid,
   input  logic                      arr_rd_dirty,
   input  logic [TAG_BITS-1:0]       arr_rd_tag,
   input  logic [LINE_BITS-1:0]      arr_rd_data,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [ADDR_BITS-1:0]      wb_addr,
   output logic [LINE_BITS-1:0]      wb_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_BITS-1:0]      mem_req_addr,
   input  logic                      mem_resp_valid,
   input  logic [LINE_BITS-1:0]      mem_resp_data,
   output logic                      arr_wr_en,
   output logic [INDEX_BITS-1:0]     arr_wr_index,
   output logic [WAY_BITS-1:0]       arr_wr_way,
   output logic [TAG_BITS-1:0]       arr_wr_tag,
   output logic [LINE_BITS-1:0]      arr_wr_data,
   output logic                      access_valid,
   output logic [WAY_BITS-1:0]       current_access,
   output logic                      fill_done,
   output logic [LINE_BITS-1:0]      fill_data
);

   fill_state_t           state;
   logic [INDEX_BITS-1:0] index_q;
   logic [TAG_BITS-1:0]   tag_q;
   logic [WAY_BITS-1:0]   victim_way;
   logic [WAY_BITS-1:0]   enc_way;

   way_encoder_lx #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_way_encoder (
      .one_hot (selected_way),
      .way     (enc_way)
   );

   // selected_way is only valid during SELECT, so the read way is taken straight from the encoder.
   assign arr_rd_way = arr_rd_en ? enc_way : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         index_q        <= '0;
         tag_q          <= '0;
         victim_way     <= '0;
         miss_ready     <= 1'b1;
         arr_rd_en      <= 1'b0;
         arr_rd_index   <= '0;
         wb_valid       <= 1'b0;
         wb_addr        <= '0;
         wb_data        <= '0;
         mem_req_valid  <= 1'b0;
         mem_req_addr   <= '0;
         arr_wr_en      <= 1'b0;
         arr_wr_index   <= '0;
         arr_wr_way     <= '0;
         arr_wr_tag     <= '0;
         arr_wr_data    <= '0;
         access_valid   <= 1'b0;
         current_access <= '0;
         fill_done      <= 1'b0;
         fill_data      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_valid && miss_ready) begin
                  index_q      <= miss_index;
                  tag_q        <= miss_tag;
                  miss_ready   <= 1'b0;
                  arr_rd_en    <= 1'b1;
                  arr_rd_index <= miss_index;
                  state        <= SELECT;
               end
            end
            SELECT: begin
               victim_way <= enc_way;
               arr_rd_en  <= 1'b0;
               state      <= READ;
            end
            READ: begin
               if (arr_rd_valid && arr_rd_dirty) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= {arr_rd_tag, index_q};
                  wb_data  <= arr_rd_data;
                  state    <= WRITEBACK;
               end else begin
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {tag_q, index_q};
                  state         <= FETCH_REQ;
               end
            end
            WRITEBACK: begin
               if (wb_ready) begin
                  wb_valid      <= 1'b0;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {tag_q, index_q};
                  state         <= FETCH_REQ;
               end
            end
            FETCH_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (mem_resp_valid) begin
                  arr_wr_en      <= 1'b1;
                  arr_wr_index   <= index_q;
                  arr_wr_way     <= victim_way;
                  arr_wr_tag     <= tag_q;
                  arr_wr_data    <= mem_resp_data;
                  access_valid   <= 1'b1;
                  current_access <= victim_way;
                  fill_done      <= 1'b1;
                  fill_data      <= mem_resp_data;
                  state          <= INSTALL;
               end
            end
            INSTALL: begin
               arr_wr_en    <= 1'b0;
               access_valid <= 1'b0;
               fill_done    <= 1'b0;
               miss_ready   <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_victim_fill_controller_lx.sv
// tb/tb_victim_fill_controller_lx.sv - randomized self-checking bench for victim_fill_controller_lx
module tb_victim_fill_controller_lx;

   localparam int NW = 8;
   localparam int IB = 8;
   localparam int TB = 20;
   localparam int LB = 128;
   localparam int WB = 3;
   localparam int AB = TB + IB;

   logic          clock, reset;
   logic          miss_valid, miss_ready;
   logic [IB-1:0] miss_index;
   logic [TB-1:0] miss_tag;
   logic [NW-1:0] selected_way;
   logic          arr_rd_en;
   logic [IB-1:0] arr_rd_index;
   logic [WB-1:0] arr_rd_way;
   logic          arr_rd_valid, arr_rd_dirty;
   logic [TB-1:0] arr_rd_tag;
   logic [LB-1:0] arr_rd_data;
   logic          wb_valid, wb_ready;
   logic [AB-1:0] wb_addr;
   logic [LB-1:0] wb_data;
   logic          mem_req_valid, mem_req_ready;
   logic [AB-1:0] mem_req_addr;
   logic          mem_resp_valid;
   logic [LB-1:0] mem_resp_data;
   logic          arr_wr_en;
   logic [IB-1:0] arr_wr_index;
   logic [WB-1:0] arr_wr_way;
   logic [TB-1:0] arr_wr_tag;
   logic [LB-1:0] arr_wr_data;
   logic          access_valid;
   logic [WB-1:0] current_access;
   logic          fill_done;
   logic [LB-1:0] fill_data;

   victim_fill_controller_lx #(
      .NUMBER_OF_WAYS(NW), .INDEX_BITS(IB), .TAG_BITS(TB), .LINE_BITS(LB)
   ) dut (
      .clock(clock), .reset(reset),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index), .miss_tag(miss_tag),
      .selected_way(selected_way),
      .arr_rd_en(arr_rd_en), .arr_rd_index(arr_rd_index), .arr_rd_way(arr_rd_way),
      .arr_rd_valid(arr_rd_valid), .arr_rd_dirty(arr_rd_dirty), .arr_rd_tag(arr_rd_tag), .arr_rd_data(arr_rd_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .arr_wr_en(arr_wr_en), .arr_wr_index(arr_wr_index), .arr_wr_way(arr_wr_way),
      .arr_wr_tag(arr_wr_tag), .arr_wr_data(arr_wr_data),
      .access_valid(access_valid), .current_access(current_access),
      .fill_done(fill_done), .fill_data(fill_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One miss as the outside world sees it: k = cycles wb_ready is held low,
   // q = cycles mem_req_ready is held low, r = cycles from fetch handshake to response.
   typedef struct {
      bit [IB-1:0] idx;
      bit [TB-1:0] tag;
      bit [NW-1:0] sel;
      bit          vvalid, vdirty;
      bit [TB-1:0] vtag;
      bit [LB-1:0] vdata, fdata;
      int          k, q, r, gap;
      bit          stray, rst_mid;
      int          lit_way, lit_fill;
      bit          lit_req_on, lit_wb_on;
      bit [AB-1:0] lit_req, lit_wb;
   } txn_t;

   int   checks = 0;
   int   failures = 0;
   txn_t pend[$];
   txn_t cur;
   bit   active, cur_wb, rst_pending;
   int   t, cur_w, cur_r, cur_f, cycles;

   task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0d)", nm, act, req, t);
      end
   endtask

   function automatic int exp_way(input bit [NW-1:0] s);
      bit [NW-1:0] low;
      low = s & (~s + 1'b1);
      return $clog2(low);
   endfunction

   function automatic bit [LB-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic txn_t blank();
      txn_t x;
      x.idx = $urandom; x.tag = $urandom; x.sel = $urandom;
      x.vvalid = $urandom; x.vdirty = $urandom; x.vtag = $urandom;
      x.vdata = rnd_line(); x.fdata = rnd_line();
      x.k = $urandom_range(0, 3); x.q = $urandom_range(0, 3); x.r = $urandom_range(1, 4);
      x.gap = $urandom_range(0, 2);
      x.stray = 0; x.rst_mid = 0;
      x.lit_way = -1; x.lit_fill = -1;
      x.lit_req_on = 0; x.lit_wb_on = 0; x.lit_req = '0; x.lit_wb = '0;
      return x;
   endfunction

   task automatic chk_reset_vals(input string nm);
      chk({nm, ".miss_ready"}, miss_ready, 1);
      chk({nm, ".strobes"}, {arr_rd_en, wb_valid, mem_req_valid, arr_wr_en, access_valid, fill_done}, 0);
      chk({nm, ".rd_fields"}, {arr_rd_index, arr_rd_way}, 0);
      chk({nm, ".wb_addr"}, wb_addr, 0);
      chk({nm, ".wb_data"}, wb_data, 0);
      chk({nm, ".mem_req_addr"}, mem_req_addr, 0);
      chk({nm, ".wr_fields"}, {arr_wr_index, arr_wr_way, arr_wr_tag, current_access}, 0);
      chk({nm, ".arr_wr_data"}, arr_wr_data, 0);
      chk({nm, ".fill_data"}, fill_data, 0);
   endtask

   task automatic compare_cycle();
      bit rd, wb, rq, wr;
      rd = 0; wb = 0; rq = 0; wr = 0;
      if (active) begin
         rd = (t == 1);
         wb = cur_wb && t >= 3 && t <= 3 + cur.k;
         rq = t >= 3 + cur_w && t <= 3 + cur_w + cur.q;
         wr = (t == cur_f);
      end
      chk("miss_ready", miss_ready, !active);
      chk("arr_rd_en", arr_rd_en, rd);
      chk("wb_valid", wb_valid, wb);
      chk("mem_req_valid", mem_req_valid, rq);
      chk("arr_wr_en", arr_wr_en, wr);
      chk("access_valid", access_valid, wr);
      chk("fill_done", fill_done, wr);
      if (rd) chk("arr_rd_index", arr_rd_index, cur.idx);
      if (wb) begin
         chk("wb_addr", wb_addr, {cur.vtag, cur.idx});
         chk("wb_data", wb_data, cur.vdata);
         if (cur.lit_wb_on) chk("wb_addr_lit", wb_addr, cur.lit_wb);
      end
      if (rq) begin
         chk("mem_req_addr", mem_req_addr, {cur.tag, cur.idx});
         if (cur.lit_req_on) chk("mem_req_addr_lit", mem_req_addr, cur.lit_req);
      end
      if (wr) begin
         chk("arr_wr_index", arr_wr_index, cur.idx);
         chk("arr_wr_way", arr_wr_way, exp_way(cur.sel));
         chk("arr_wr_tag", arr_wr_tag, cur.tag);
         chk("arr_wr_data", arr_wr_data, cur.fdata);
         chk("current_access", current_access, exp_way(cur.sel));
         chk("fill_data", fill_data, cur.fdata);
         if (cur.lit_way >= 0) begin
            chk("arr_wr_way_lit", arr_wr_way, cur.lit_way);
            chk("current_access_lit", current_access, cur.lit_way);
         end
      end
      if (active && cur.lit_fill == t) chk("fill_done_lit", fill_done, 1);
   endtask

   task automatic drive_cycle();
      txn_t f;
      selected_way = $urandom; arr_rd_valid = $urandom; arr_rd_dirty = $urandom;
      arr_rd_tag = $urandom; arr_rd_data = rnd_line();
      wb_ready = $urandom; mem_req_ready = $urandom;
      mem_resp_valid = 0; mem_resp_data = rnd_line();
      if (active) begin
         if (t == 1) selected_way = cur.sel;
         if (t == 2) begin
            arr_rd_valid = cur.vvalid; arr_rd_dirty = cur.vdirty;
            arr_rd_tag = cur.vtag; arr_rd_data = cur.vdata;
         end
         if (cur_wb && t >= 3 && t <= 3 + cur.k) wb_ready = (t == 3 + cur.k);
         if (t >= 3 + cur_w && t <= 3 + cur_w + cur.q) mem_req_ready = (t == 3 + cur_w + cur.q);
         if (t == cur_r) begin
            mem_resp_valid = 1; mem_resp_data = cur.fdata;
         end else if (t < 3 + cur_w || t > cur_r) begin
            mem_resp_valid = cur.stray || ($urandom_range(0, 3) == 0);
         end
      end else begin
         mem_resp_valid = ($urandom_range(0, 3) == 0);
      end
      if (pend.size() > 0 && pend[0].gap == 0) begin
         miss_valid = 1; miss_index = pend[0].idx; miss_tag = pend[0].tag;
      end else begin
         miss_valid = 0; miss_index = $urandom; miss_tag = $urandom;
         if (!active && pend.size() > 0) begin
            f = pend[0]; f.gap--; pend[0] = f;
         end
      end
   endtask

   initial begin
      txn_t x;
      reset = 1; miss_valid = 0; miss_index = 0; miss_tag = 0; selected_way = 0;
      arr_rd_valid = 0; arr_rd_dirty = 0; arr_rd_tag = 0; arr_rd_data = 0;
      wb_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
      active = 0; rst_pending = 0; t = 0; cycles = 0;

      x = blank(); x.idx = 8'h12; x.tag = 20'hABCDE; x.sel = 8'b0000_0100;
      x.vvalid = 1; x.vdirty = 0; x.k = 0; x.q = 0; x.r = 1; x.gap = 1;
      x.lit_way = 2; x.lit_fill = 5; x.lit_req_on = 1; x.lit_req = 28'hABCDE12;
      pend.push_back(x);
      x = blank(); x.idx = 8'h12; x.sel = 8'b1000_0000; x.vvalid = 1; x.vdirty = 1;
      x.vtag = 20'h00011; x.k = 3; x.gap = 2; x.stray = 1;
      x.lit_way = 7; x.lit_wb_on = 1; x.lit_wb = 28'h0001112;
      pend.push_back(x);
      x = blank(); x.sel = 8'b0000_0000; x.lit_way = 0; pend.push_back(x);
      x = blank(); x.sel = 8'b0011_0000; x.lit_way = 4; pend.push_back(x);
      x = blank(); x.q = 1; x.r = 5; x.rst_mid = 1; x.stray = 1; pend.push_back(x);
      x = blank(); x.gap = 1; x.vvalid = 0; x.q = 0; x.r = 1; x.sel = 8'b0000_0010; x.lit_way = 1;
      pend.push_back(x);
      x = blank(); x.gap = 0; x.sel = 8'b0100_0000; x.lit_way = 6; pend.push_back(x);
      x = blank(); x.gap = 0; pend.push_back(x);
      for (int n = 0; n < 40; n++) begin
         x = blank();
         case ($urandom_range(0, 3))
            0:       x.sel = '0;
            1:       x.sel = 8'(1 << $urandom_range(0, 7));
            default: x.sel = $urandom;
         endcase
         pend.push_back(x);
      end

      @(negedge clock);
      @(negedge clock);
      #1 chk_reset_vals("reset");
      @(negedge clock);
      reset = 0;

      while ((pend.size() > 0 || active) && cycles < 20000) begin
         @(negedge clock);
         cycles++;
         if (rst_pending) begin
            reset = 0;
            rst_pending = 0;
         end
         compare_cycle();
         drive_cycle();
         #1;
         if (active && t == 1) chk("arr_rd_way", arr_rd_way, exp_way(cur.sel));
         if (active && cur.rst_mid && t == 3 + cur_w + cur.q + 2) begin
            #1 reset = 1;
            #1 chk_reset_vals("midrst");
            miss_valid = 0;
            mem_resp_valid = 0;
            active = 0;
            rst_pending = 1;
         end else if (!active && miss_valid) begin
            cur = pend.pop_front();
            cur_wb = cur.vvalid && cur.vdirty;
            cur_w = cur_wb ? cur.k + 1 : 0;
            cur_r = 3 + cur_w + cur.q + cur.r;
            cur_f = cur_r + 1;
            active = 1;
            t = 1;
         end else if (active) begin
            if (t == cur_f) active = 0;
            else t++;
         end
      end
      if (pend.size() != 0 || active) begin
         checks++;
         failures++;
         $display("FAIL timeout pending=%0d active=%0d", pend.size(), active);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
